mem_port_arbiter: RTL

- Shares one single-ported unified memory between two requesters: instruction fetch (IF) and the data load/store path (D).
- Sits between the IF stage / ALU-DataMem stage and the memory array.
- Sequences each access over a variable-latency memory handshake.
- Arbitrates with data-first priority plus a fetch anti-starvation limit.
- Bounds every access with a timeout.

---
 rtl/mem_port_arbiter_pkg.sv | 32 +++
 rtl/mem_port_arbiter_arb_priority_pick.sv | 20 ++
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and encodings for the IF/D memory port arbiter.
// Optional statistics outputs are enabled in the top by defining MEM_ARB_STATS_EN.
package mem_port_arbiter_pkg;

  localparam int WORD     = 16;
  localparam int STREAK_W = 4;
  localparam int TIMER_W  = 8;

  localparam logic [1:0] ARB_IDLE = 2'b00;
  localparam logic [1:0] ARB_BUSY = 2'b01;
  localparam logic [1:0] ARB_DONE = 2'b10;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam logic [STREAK_W-1:0] STREAK_SAT = 4'd15;

  typedef struct packed {
    logic            we;
    logic [WORD-1:0] addr;
    logic [WORD-1:0] wdata;
  } mem_cmd_t;

  // Streak grows only while a fetch is being held off; a free D grant restarts it.
  function automatic logic [STREAK_W-1:0] streak_after_d(input logic [STREAK_W-1:0] streak,
                                                         input logic            if_waiting);
    if (!if_waiting)
      return '0;
    return (streak == STREAK_SAT) ? streak : streak + 4'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_priority_pick.sv
// Winner selection: data path first, unless fetch has been held off MAX_D_STREAK times in a row.
module arb_priority_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 3
) (
  input  logic                if_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_if,
  output logic                grant_d
);

  logic w_d_allowed;

  assign w_d_allowed = !if_req || (int'(streak) < MAX_D_STREAK);
  assign grant_d     = d_req && w_d_allowed;
  assign grant_if    = if_req && !grant_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the load/store path.
// Define MEM_ARB_STATS_EN to add grant and fetch-wait counters as extra outputs.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 3,
  parameter int TIMEOUT      = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_req,
  input  logic [WORD-1:0] if_addr,
  output logic            if_ack,
  output logic [WORD-1:0] if_data,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [WORD-1:0] d_addr,
  input  logic [WORD-1:0] d_wdata,
  output logic            d_ack,
  output logic [WORD-1:0] d_rdata,
  output logic            err,
  output logic            mem_en,
  output logic            mem_we,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]     stat_if_grants,
  output logic [15:0]     stat_d_grants,
  output logic [15:0]     stat_if_wait
`endif
);

  logic [1:0]          r_state;
  logic                r_owner;
  logic [STREAK_W-1:0] r_streak;
  logic [TIMER_W-1:0]  r_timer;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [WORD-1:0]     r_mem_addr;
  logic [WORD-1:0]     r_mem_wdata;
  logic [WORD-1:0]     r_if_data;
  logic [WORD-1:0]     r_d_rdata;
  logic                r_err;

  logic                w_grant_if;
  logic                w_grant_d;
  logic                w_timed_out;
  mem_cmd_t            w_cmd;

  arb_priority_pick #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_pick (
    .if_req  (if_req),
    .d_req   (d_req),
    .streak  (r_streak),
    .grant_if(w_grant_if),
    .grant_d (w_grant_d)
  );

  // Fetches never write, so their command carries zero write data.
  always_comb begin
    w_cmd.we    = 1'b0;
    w_cmd.addr  = if_addr;
    w_cmd.wdata = '0;
    if (w_grant_d) begin
      w_cmd.we    = d_we;
      w_cmd.addr  = d_addr;
      w_cmd.wdata = d_wdata;
    end
  end

  assign w_timed_out = (r_timer == TIMER_W'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_owner     <= OWN_IF;
      r_streak    <= '0;
      r_timer     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_data   <= '0;
      r_d_rdata   <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_d || w_grant_if) begin
            r_state     <= ARB_BUSY;
            r_owner     <= w_grant_d ? OWN_D : OWN_IF;
            r_streak    <= w_grant_d ? streak_after_d(r_streak, if_req) : '0;
            r_timer     <= '0;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_cmd.we;
            r_mem_addr  <= w_cmd.addr;
            r_mem_wdata <= w_cmd.wdata;
          end
        end
        ARB_BUSY: begin
          r_timer <= r_timer + 1'b1;
          if (mem_ready) begin
            if (r_owner == OWN_IF)
              r_if_data <= mem_rdata;
            else if (!r_mem_we)
              r_d_rdata <= mem_rdata;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_state  <= ARB_DONE;
          end else if (w_timed_out) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_err    <= 1'b1;
            r_state  <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          r_state <= ARB_IDLE;
          r_err   <= 1'b0;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign if_ack    = (r_state == ARB_DONE) && (r_owner == OWN_IF);
  assign d_ack     = (r_state == ARB_DONE) && (r_owner == OWN_D);
  assign err       = r_err;
  assign busy      = (r_state != ARB_IDLE);
  assign if_data   = r_if_data;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_stat_if_grants;
  logic [15:0] r_stat_d_grants;
  logic [15:0] r_stat_if_wait;
  logic        w_if_owns;

  // Fetch is waiting whenever it asks and does not currently hold the port.
  assign w_if_owns = (r_state != ARB_IDLE) && (r_owner == OWN_IF);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stat_if_grants <= '0;
      r_stat_d_grants  <= '0;
      r_stat_if_wait   <= '0;
    end else begin
      if (r_state == ARB_IDLE && w_grant_d)
        r_stat_d_grants <= r_stat_d_grants + 16'd1;
      if (r_state == ARB_IDLE && w_grant_if)
        r_stat_if_grants <= r_stat_if_grants + 16'd1;
      if (if_req && !w_if_owns)
        r_stat_if_wait <= r_stat_if_wait + 16'd1;
    end
  end

  assign stat_if_grants = r_stat_if_grants;
  assign stat_d_grants  = r_stat_d_grants;
  assign stat_if_wait   = r_stat_if_wait;
`endif

endmodule
